// File: rtl/vic_vec_pkg.sv
// Shared definitions for the vectored interrupt controller: register map,
// bus handshake states and small helpers.
package vic_vec_pkg;

  localparam logic [4:0] VIC_STATUS = 5'h00;
  localparam logic [4:0] VIC_MASK   = 5'h04;
  localparam logic [4:0] VIC_CLEAR  = 5'h08;
  localparam logic [4:0] VIC_MODE   = 5'h0C;
  localparam logic [4:0] VIC_ROUTE  = 5'h10;
  localparam logic [4:0] VIC_VECTOR = 5'h14;
  localparam logic [4:0] VIC_SWSET  = 5'h18;

  localparam int unsigned VEC_VALID_BIT = 31;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_ACK  = 1'b1
  } wb_state_t;

  // Expand Wishbone byte selects into a 32-bit bit mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      if (sel[b]) m[8*b +: 8] = 8'hFF;
    end
    return m;
  endfunction

  // Mask of implemented source bits for a given source count (1..32).
  function automatic logic [31:0] src_valid(input int unsigned n);
    return 32'hFFFF_FFFF >> (32 - n);
  endfunction

endpackage

// File: rtl/vic_vec_prio_enc.sv
// Lowest-index priority encoder used to form the IRQ vector.
module vic_prio_enc #(
  parameter int unsigned SOURCES = 8
) (
  input  logic [SOURCES-1:0] i_pend,
  output logic               o_valid,
  output logic [4:0]         o_idx
);

  // Scan upward and keep the first set bit so ties resolve to the lowest index.
  always_comb begin
    logic found;
    found   = 1'b0;
    o_idx   = '0;
    for (int unsigned i = 0; i < SOURCES; i++) begin
      if (i_pend[i] && !found) begin
        found = 1'b1;
        o_idx = 5'(i);
      end
    end
    o_valid = found;
  end

endmodule

// File: rtl/vic_vec.sv
// Vectored interrupt controller on a Wishbone slave port: edge/level sources,
// software set, IRQ/FIQ routing and a lowest-index IRQ vector.
module vic_vec
  import vic_vec_pkg::*;
#(
  parameter int unsigned SOURCES    = 8,
  parameter logic [31:0] MASK_RESET = 32'hFFFF_FFFF,
  parameter logic [31:0] MODE_RESET = 32'h0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [31:0]        i_wb_dat,
  input  logic [4:0]         i_wb_adr,
  input  logic               i_wb_stb,
  input  logic               i_wb_cyc,
  input  logic               i_wb_wen,
  input  logic [3:0]         i_wb_sel,
  output logic [31:0]        o_wb_dat,
  output logic               o_wb_ack,
  input  logic [SOURCES-1:0] i_irq,
  output logic               o_irq,
  output logic               o_fiq
);

  localparam logic [31:0] VALID = src_valid(SOURCES);

  wb_state_t   wb_state_q, wb_state_d;
  logic [31:0] wb_dat_q, wb_dat_d;
  logic        wb_ack_q, wb_ack_d;
  logic        irq_out_q, irq_out_d;
  logic        fiq_out_q, fiq_out_d;
  logic [31:0] status_q, status_d;
  logic [31:0] mask_q, mask_d;
  logic [31:0] mode_q, mode_d;
  logic [31:0] route_q, route_d;
  logic [31:0] irq_q, irq_d;

  logic [31:0] irq_in;
  logic [31:0] pend_irq;
  logic [31:0] pend_fiq;
  logic [31:0] rd_data;
  logic        vec_valid;
  logic [4:0]  vec_idx;

  // Widen the source inputs so all internal state is a uniform 32 bits;
  // unimplemented bits stay constant zero.
  always_comb begin
    irq_in              = '0;
    irq_in[SOURCES-1:0] = i_irq;
    pend_irq            = status_q & ~mask_q & ~route_q;
    pend_fiq            = status_q & ~mask_q & route_q;
  end

  vic_prio_enc #(
    .SOURCES(SOURCES)
  ) u_prio (
    .i_pend (pend_irq[SOURCES-1:0]),
    .o_valid(vec_valid),
    .o_idx  (vec_idx)
  );

  // Read mux over current (pre-edge) register state.
  always_comb begin
    rd_data = '0;
    unique case (i_wb_adr)
      VIC_STATUS: rd_data = status_q;
      VIC_MASK:   rd_data = mask_q;
      VIC_MODE:   rd_data = mode_q;
      VIC_ROUTE:  rd_data = route_q;
      VIC_VECTOR: begin
        rd_data[VEC_VALID_BIT] = vec_valid;
        rd_data[4:0]           = vec_idx;
      end
      default:    rd_data = '0;
    endcase
  end

  // Bus FSM next state, register writes, status update and CPU outputs.
  always_comb begin
    logic        access;
    logic [31:0] wm;
    logic [31:0] wdat;
    logic [31:0] clr;
    logic [31:0] sw;

    wb_state_d = WB_IDLE;
    wb_ack_d   = 1'b0;
    wb_dat_d   = wb_dat_q;
    mask_d     = mask_q;
    mode_d     = mode_q;
    route_d    = route_q;
    clr        = '0;
    sw         = '0;
    wm         = byte_mask(i_wb_sel);
    wdat       = i_wb_dat & wm;
    access     = (wb_state_q == WB_IDLE) && i_wb_stb && i_wb_cyc;

    if (access) begin
      wb_state_d = WB_ACK;
      wb_ack_d   = 1'b1;
      if (!i_wb_wen) begin
        wb_dat_d = rd_data;
      end else begin
        unique case (i_wb_adr)
          VIC_MASK:  mask_d  = ((mask_q  & ~wm) | wdat) & VALID;
          VIC_MODE:  mode_d  = ((mode_q  & ~wm) | wdat) & VALID;
          VIC_ROUTE: route_d = ((route_q & ~wm) | wdat) & VALID;
          VIC_CLEAR: clr     = wdat;
          VIC_SWSET: sw      = wdat;
          default:   ;
        endcase
      end
    end

    // Edge bits: set terms are OR'd after the clear so a same-cycle edge wins.
    // Level bits simply track the sampled input. Old MODE governs this edge.
    status_d  = (mode_q & ((status_q & ~clr) | (irq_in & ~irq_q) | sw))
              | (~mode_q & irq_in);
    irq_d     = irq_in;
    irq_out_d = |pend_irq;
    fiq_out_d = |pend_fiq;
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wb_state_q <= WB_IDLE;
      wb_dat_q   <= '0;
      wb_ack_q   <= 1'b0;
      irq_out_q  <= 1'b0;
      fiq_out_q  <= 1'b0;
      status_q   <= '0;
      mask_q     <= MASK_RESET & VALID;
      mode_q     <= MODE_RESET & VALID;
      route_q    <= '0;
      irq_q      <= '0;
    end else begin
      wb_state_q <= wb_state_d;
      wb_dat_q   <= wb_dat_d;
      wb_ack_q   <= wb_ack_d;
      irq_out_q  <= irq_out_d;
      fiq_out_q  <= fiq_out_d;
      status_q   <= status_d;
      mask_q     <= mask_d;
      mode_q     <= mode_d;
      route_q    <= route_d;
      irq_q      <= irq_d;
    end
  end

  assign o_wb_dat = wb_dat_q;
  assign o_wb_ack = wb_ack_q;
  assign o_irq    = irq_out_q;
  assign o_fiq    = fiq_out_q;

endmodule
